// File: rtl/computer_pkg.sv
// computer_pkg: shared port addresses, UART status bit indices and transmitter states
package computer_pkg;
  localparam logic [7:0] UART_TX_ADDR = 8'hE0;
  localparam logic [7:0] UART_CTRL_ADDR = 8'hE1;
  localparam logic [7:0] UART_STAT_ADDR = 8'hF0;
  localparam int ST_BUSY = 0;
  localparam int ST_FULL = 1;
  localparam int ST_OVR = 2;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_t;
endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: counts CLKS_PER_BIT cycles per serial bit and pulses bit_done on the last one
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic bit_done
);
  localparam int W = $clog2(CLKS_PER_BIT);
  logic [W-1:0] cnt;
  assign bit_done = run && cnt == W'(CLKS_PER_BIT - 1);
  always_ff @(posedge clock)
    cnt <= (reset || clear || !run || bit_done) ? '0 : cnt + W'(1);
endmodule

// File: rtl/uart_tx_port.sv
// uart_tx_port: 8N1 serial transmitter with a 1-deep holding register behind output port E0
module uart_tx_port
  import computer_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       port_wr,
  input  logic       ctrl_wr,
  input  logic [7:0] port_data,
  output logic       tx,
  output logic [7:0] status
);
  uart_tx_state_t state, state_nx;
  logic [7:0] hold;
  logic       hold_full;
  logic       overrun;
  logic [9:0] shift;
  logic [2:0] idx;
  logic       bit_done;
  logic       load;
  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clock(clock),
    .reset(reset),
    .clear(load),
    .run(state != IDLE),
    .bit_done(bit_done)
  );
  // hold moves into the shifter from idle, or straight after a stop bit for back-to-back frames
  assign load = hold_full && (state == IDLE || (state == STOP && bit_done));
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    state_nx = hold_full ? START : IDLE;
      START:   state_nx = bit_done ? DATA : START;
      DATA:    state_nx = (bit_done && idx == 3'd7) ? STOP : DATA;
      STOP:    state_nx = bit_done ? (hold_full ? START : IDLE) : STOP;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clock)
    state <= reset ? IDLE : state_nx;
  // shifter refills with ones so tx returns high once the stop bit has been sent
  always_ff @(posedge clock) begin
    if (reset) begin
      shift     <= '1;
      tx        <= 1'b1;
      idx       <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (load) begin
        shift <= {1'b1, hold, 1'b0};
        tx    <= 1'b0;
      end else if (bit_done) begin
        shift <= {1'b1, shift[9:1]};
        tx    <= shift[1];
      end
      idx <= (state == DATA) ? idx + 3'(bit_done) : '0;
      if (port_wr && (!hold_full || load)) begin
        hold      <= port_data;
        hold_full <= 1'b1;
      end else if (load) begin
        hold_full <= 1'b0;
      end
      overrun <= (port_wr && hold_full && !load) || (overrun && !(ctrl_wr && port_data[ST_OVR]));
    end
  end
  always_comb begin
    status          = '0;
    status[ST_BUSY] = state != IDLE;
    status[ST_FULL] = hold_full;
    status[ST_OVR]  = overrun;
  end
endmodule

// File: doc/uart_tx_port.md
# uart_tx_port

Memory-mapped serial transmitter on the computer's output-port bank. It takes bytes the CPU writes to output port `E0` and sends them as 8N1 UART frames on `tx`. Its status byte is returned to the CPU through input port `F0`. It sits directly downstream of the memory block's port-write decode and is read back through the memory read mux.

## Interface
- `CLKS_PER_BIT`, 16, clock cycles per serial bit; legal range 2..255.
- `clock`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `port_wr`  in  1  one-cycle strobe; high when the CPU writes address `E0`.
- `ctrl_wr`  in  1  one-cycle strobe; high when the CPU writes address `E1`.
- `port_data`  in  8  write data, valid with either strobe.
- `tx`  out  1  serial line; idles high.
- `status`  out  8  wired to port_in `F0`.
  - `[0]` busy: shifter not idle.
  - `[1]` hold_full.
  - `[2]` overrun: sticky.
  - `[7:3]` are 0.

## Operation
- Storage is a 1-deep holding register in front of a 10-bit frame shifter.
- Frame format:
  - start bit (0);
  - `D0`..`D7`, LSB first;
  - stop bit (1).
- State machine `IDLE`/`START`/`DATA`/`STOP`, plus a bit-timer counter and a 3-bit data-bit index.
  - `IDLE`, hold_full=1 → `START`: the shifter loads from hold and hold_full clears.
  - `START` → `DATA` after `CLKS_PER_BIT` cycles.
  - `DATA` → `STOP` after 8 bits, each `CLKS_PER_BIT` cycles.
  - `STOP` → `START` at the end of the stop bit if hold_full=1 (back-to-back, no idle gap).
  - `STOP` → `IDLE` at the end of the stop bit otherwise.
- `port_wr` handling:
  - accepted when hold_full=0, or when hold is being transferred to the shifter in the same cycle; hold then loads `port_data` and hold_full=1;
  - when hold_full=1 and no transfer occurs this cycle, the byte is dropped and overrun sets.
- `ctrl_wr` with `port_data[2]`=1 clears overrun.
  - If an overrun-setting `port_wr` occurs in the same cycle, the set wins.
  - Other `ctrl_wr` bits are ignored.
- `tx` is registered: 1 in `IDLE`, otherwise the current frame bit.
- `status` is combinational from registered state, so the CPU sees it the cycle after any update.
- The bit-timer counter is `$clog2(CLKS_PER_BIT)` bits wide. It counts 0..`CLKS_PER_BIT`-1 and wraps to 0 at each bit boundary.

## Timing
- Reset values:
  - `tx`=1
  - `status`=0x00
  - state `IDLE`, hold empty, overrun 0, counters 0.
- Reset mid-frame aborts the frame: `tx`=1 after the reset edge and the hold contents are discarded.
- Write latency (strobe sampled at edge N, idle shifter):
  - hold_full=1 after edge N;
  - start bit on `tx` after edge N+1, with busy=1 and hold_full=0;
  - frame occupies edges N+1..N+1+10·`CLKS_PER_BIT`;
  - busy falls after the final stop-bit cycle.
- Back-to-back frames: while hold_full=1 at the end of the stop bit, the next start bit follows with zero idle cycles. Sustained rate is one byte per 10·`CLKS_PER_BIT` cycles.
- `port_wr` and `ctrl_wr` in the same cycle are both honoured.

## Structure
- Shared package `computer_pkg` holds:
  - port address constants `UART_TX_ADDR`=8'hE0, `UART_CTRL_ADDR`=8'hE1, `UART_STAT_ADDR`=8'hF0;
  - status bit indices `ST_BUSY`=0, `ST_FULL`=1, `ST_OVR`=2;
  - enum `uart_tx_state_t`.
- One natural sub-module: `uart_bit_timer`. It is the `CLKS_PER_BIT` counter emitting a one-cycle `bit_done` pulse, and is cleared on frame load.

## Test plan
All scenarios run with `CLKS_PER_BIT`=4.

- Reset, then hold idle for 20 cycles → `tx`=1, `status`=0x00 throughout.
- Write 0x55 at edge N → `tx` sequence 0,1,0,1,0,1,0,1,0,1, each held 4 cycles, starting after edge N+1. `status`=0x02 after edge N, 0x01 after edge N+1, 0x00 after edge N+41.
- Write 0xA3, then write 0x0F at edge N+5 → the 0x0F frame's start bit begins immediately after the 0xA3 stop bit, with no idle cycle. No overrun.
- Write 0x11, 0x22, 0x33 on three consecutive cycles:
  - the first two are transmitted and 0x33 is dropped;
  - `status`=0x07 until the first frame completes;
  - ctrl_wr 0x04 → overrun clears.
- Assert `reset` for one cycle at the 5th data bit of a 0xFF frame → `tx`=1 the next cycle, `status`=0x00, and no further frame bits are driven.
- Coincident `port_wr` (hold full) and `ctrl_wr` 0x04 → overrun remains 1.
